uart_tx: RTL
============

Name: uart_tx

Overview:
- 8N1 UART serializer; the stage directly downstream of the transmit driver.
- Accepts one byte per XMitGo handshake and drives it LSB-first on the serial line TxD.
- Reports readiness back to the driver on TxEmpty.
- Sits between the driver and the board TX pin.

Parameters:
- CLKS_PER_BIT, 434, Clock cycles per serial bit (50 MHz / 115200 baud); legal values are 2 and above.

Ports:
- Clock  in  1  system clock, all logic on posedge.
- Reset  in  1  asynchronous, active-low reset.
- XMitGo  in  1  transmit request, level; held high by the driver until TxEmpty falls.
- TxData  in  8  byte to send; sampled only in the cycle of acceptance.
- TxEmpty  out  1  high = idle and able to accept a byte.
- TxD  out  1  serial output; idle/mark = 1.

Behaviour:
- Reset (Reset=0, async): TxD=1, TxEmpty=1, state=IDLE, bit counter=0, baud counter=0, Armed=1. All outputs are registered.
- Armed flag: cleared on acceptance; set again in any cycle where XMitGo=0. This prevents a second send from a level-held XMitGo that has not yet dropped.
- States:
  - IDLE: on a posedge with XMitGo=1 and Armed=1, latch TxData into the shift register. Next state START, TxEmpty<=0, TxD<=0, baud counter<=0.
  - START: hold TxD=0 for CLKS_PER_BIT cycles, then go to DATA and drive bit 0.
  - DATA: drive shift[0] for CLKS_PER_BIT cycles, then shift right. Repeat for 8 bits using a bit counter 0..7. After bit 7, go to STOP (or PARITY when the feature is enabled).
  - STOP: TxD=1 for CLKS_PER_BIT cycles. At the final cycle, state<=IDLE and TxEmpty<=1.
- Latency: TxEmpty falls and the start bit begins on the first edge after acceptance. A frame is exactly 10*CLKS_PER_BIT cycles from the TxD falling edge to TxEmpty rising.
- Back-to-back: if XMitGo fell during the frame and is high again when TxEmpty returns, accept on the next edge. This gives a minimum of one IDLE cycle between frames.
- XMitGo still high at end of frame with Armed=0: stay in IDLE; no retransmit.
- TxData changes mid-frame: ignored, because the shift register holds the latched copy.
- XMitGo asserted while busy: ignored; the Armed rules above still apply.
- Baud counter width: $clog2(CLKS_PER_BIT). It wraps to 0 at CLKS_PER_BIT-1, where a bit-end tick fires.
- Reset asserted mid-frame: TxD returns to 1 immediately (a truncated frame is acceptable) and TxEmpty=1. After release, the block is in IDLE with Armed=1.
- Illegal state encoding: go to IDLE with TxD=1 and TxEmpty=1.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: adds a PARITY state between DATA and STOP that drives the even-parity bit (XOR of the latched byte) for CLKS_PER_BIT cycles. Frame = 11*CLKS_PER_BIT cycles.
- Undefined: no PARITY state, no parity logic; frame = 10*CLKS_PER_BIT cycles.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic[2:0] tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - localparam DATA_BITS=8;
  - localparam logic PARITY_EVEN=1'b0.
- Sub-module uart_baud_counter (params CLKS_PER_BIT; ports Clock, Reset, Clear, Tick): free-running modulo counter, cleared on acceptance, Tick high on its last count.
- The state machine, shift register and Armed flag stay in uart_tx.

Test Plan:
1. Reset: hold Reset=0 for 3 cycles, then release with XMitGo=0 -> TxD=1 and TxEmpty=1 throughout; an async assert mid-cycle forces TxD=1 within the same cycle.
2. Single byte, CLKS_PER_BIT=4: XMitGo=1, TxData=8'h48 -> TxEmpty=0 after 1 edge. TxD = 0 for 4 cycles, then bits 0,0,0,1,0,0,1,0 (4 cycles each), then 1 for 4. TxEmpty=1 exactly 40 cycles after TxD falls.
3. Level-held XMitGo: keep XMitGo=1 for 100 cycles with TxData=8'h41 -> exactly one frame is sent; TxD stays 1 after the stop bit until XMitGo drops and rises again.
4. Driver-style sequence with a behavioural driver sending "Hi\n" (8'h48, 8'h69, 8'h0A), dropping XMitGo one cycle after TxEmpty falls -> the decoded serial stream equals the three bytes in order, with no extra or missing frames.
5. Reset mid-frame: assert Reset during data bit 3 of 8'hFF -> TxD=1 and TxEmpty=1 immediately. After release, the next send of 8'h55 produces a clean full frame.
6. With UART_TX_PARITY_EN and CLKS_PER_BIT=4: send 8'h07 -> parity bit 1; send 8'h03 -> parity bit 0. Frame is 44 cycles long.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int   DATA_BITS   = 8;
    localparam logic PARITY_EVEN = 1'b0;

endpackage

// File: rtl/uart_baud_counter.sv
// Free-running modulo-CLKS_PER_BIT counter; Tick marks the last cycle of each bit.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Clear,
    output logic Tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign Tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (Clear || Tick) cnt_d = '0;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART serializer, LSB first, with a level-handshake re-arm guard.
// Optional even parity bit when UART_TX_PARITY_EN is defined.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 XMitGo,
    input  logic [DATA_BITS-1:0] TxData,
    output logic                 TxEmpty,
    output logic                 TxD
);

    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    tx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 txd_q, txd_d;
    logic                 empty_q, empty_d;
    logic                 armed_q, armed_d;
    logic                 tick;
    logic                 accept;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    // Armed blocks a level-held XMitGo from launching a second frame.
    assign accept = (state_q == IDLE) && XMitGo && armed_q;
    assign armed_d = accept ? 1'b0 : (!XMitGo ? 1'b1 : armed_q);

    uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .Clock (Clock),
        .Reset (Reset),
        .Clear (accept),
        .Tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        txd_d   = txd_q;
        empty_d = empty_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                txd_d   = 1'b1;
                empty_d = 1'b1;
                if (accept) begin
                    state_d = START;
                    shift_d = TxData;
                    bit_d   = '0;
                    txd_d   = 1'b0;
                    empty_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_d   = (^TxData) ^ PARITY_EVEN;
`endif
                end
            end
            START: if (tick) begin
                state_d = DATA;
                txd_d   = shift_q[0];
            end
            DATA: if (tick) begin
                if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
                    txd_d   = par_q;
`else
                    state_d = STOP;
                    txd_d   = 1'b1;
`endif
                end else begin
                    bit_d   = bit_q + 1'b1;
                    shift_d = shift_q >> 1;
                    txd_d   = shift_q[1];
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (tick) begin
                state_d = STOP;
                txd_d   = 1'b1;
            end
`endif
            STOP: if (tick) begin
                state_d = IDLE;
                empty_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
                empty_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            txd_q   <= 1'b1;
            empty_q <= 1'b1;
            armed_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            txd_q   <= txd_d;
            empty_q <= empty_d;
            armed_q <= armed_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign TxD     = txd_q;
    assign TxEmpty = empty_q;

endmodule
